// File: rtl/lsu_stage_pkg.sv
// Shared definitions for the load/store stage: opcodes, size encodings,
// exception codes and FSM state type.
package lsu_stage_pkg;

    localparam logic [4:0] OP_LOAD  = 5'b00000;
    localparam logic [4:0] OP_STORE = 5'b01000;

    localparam logic [2:0] F_B  = 3'b000;
    localparam logic [2:0] F_H  = 3'b001;
    localparam logic [2:0] F_W  = 3'b010;
    localparam logic [2:0] F_D  = 3'b011;
    localparam logic [2:0] F_BU = 3'b100;
    localparam logic [2:0] F_HU = 3'b101;
    localparam logic [2:0] F_WU = 3'b110;

    localparam int unsigned EX_ILLEGAL     = 2;
    localparam int unsigned EX_LD_MISALIGN = 4;
    localparam int unsigned EX_ST_MISALIGN = 6;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWait,
        StFin,
        StDrain
    } lsu_state_e;

    // Unsigned forms only exist for loads; doubleword forms only on 64-bit cores.
    function automatic logic funct_legal(input logic [2:0] funct, input logic is_store,
                                         input int unsigned xlen);
        logic ok;
        case (funct)
            F_B, F_H, F_W: ok = 1'b1;
            F_D:           ok = (xlen == 64);
            F_BU, F_HU:    ok = !is_store;
            F_WU:          ok = !is_store && (xlen == 64);
            default:       ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational data alignment: store strobes/lane replication with
// misalignment detection, and load right-shift with sign/zero extension.
module lsu_align
    import lsu_stage_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned BE_W  = XLEN / 8,
    parameter int unsigned OFF_W = $clog2(XLEN / 8)
) (
    input  logic [1:0]       st_size_i,
    input  logic [OFF_W-1:0] st_off_i,
    input  logic [XLEN-1:0]  st_wdata_i,
    output logic [BE_W-1:0]  st_be_o,
    output logic [XLEN-1:0]  st_lane_o,
    output logic             misalign_o,
    input  logic [2:0]       ld_funct_i,
    input  logic [OFF_W-1:0] ld_off_i,
    input  logic [XLEN-1:0]  ld_rdata_i,
    output logic [XLEN-1:0]  ld_result_o
);

    logic [BE_W-1:0] be_base;
    logic [2:0]      off_mask;
    logic [XLEN-1:0] shifted;

    always_comb begin
        be_base   = '0;
        off_mask  = 3'b000;
        st_lane_o = st_wdata_i;
        // Replicating the datum into every lane puts it under whichever strobes fire.
        unique case (st_size_i)
            2'd0: begin
                be_base   = BE_W'(1);
                off_mask  = 3'b000;
                st_lane_o = {BE_W{st_wdata_i[7:0]}};
            end
            2'd1: begin
                be_base   = BE_W'(2'b11);
                off_mask  = 3'b001;
                st_lane_o = {(XLEN / 16){st_wdata_i[15:0]}};
            end
            2'd2: begin
                be_base   = BE_W'(4'hF);
                off_mask  = 3'b011;
                st_lane_o = {(XLEN / 32){st_wdata_i[31:0]}};
            end
            default: begin
                be_base   = '1;
                off_mask  = 3'b111;
                st_lane_o = st_wdata_i;
            end
        endcase
        st_be_o    = be_base << st_off_i;
        misalign_o = |(3'(st_off_i) & off_mask);
    end

    always_comb begin
        shifted = ld_rdata_i >> {ld_off_i, 3'b000};
        case (ld_funct_i)
            F_B:     ld_result_o = XLEN'($signed(shifted[7:0]));
            F_H:     ld_result_o = XLEN'($signed(shifted[15:0]));
            F_W:     ld_result_o = XLEN'($signed(shifted[31:0]));
            F_BU:    ld_result_o = XLEN'(shifted[7:0]);
            F_HU:    ld_result_o = XLEN'(shifted[15:0]);
            F_WU:    ld_result_o = XLEN'(shifted[31:0]);
            default: ld_result_o = shifted;
        endcase
    end

endmodule

// File: rtl/lsu_stage.sv
// Memory pipeline stage: issues dmem requests, aligns load data and holds a
// registered result toward writeback under stall; flush aborts in-flight work.
module lsu_stage
    import lsu_stage_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned EX_W   = 4,
    parameter int unsigned RA_W   = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4:0]           opcode_in,
    input  logic [2:0]           funct_in,
    input  logic [ADDR_W-1:0]    addr_in,
    input  logic [XLEN-1:0]      wdata_in,
    input  logic [RA_W-1:0]      rd_in,
    input  logic                 nop_in,
    input  logic                 halt_in,
    input  logic [EX_W-1:0]      ex_in,
    input  logic                 ex_valid_in,
    output logic                 out_valid,
    input  logic                 stall_in,
    output logic [XLEN-1:0]      result_out,
    output logic [RA_W-1:0]      rd_out,
    output logic [4:0]           opcode_out,
    output logic                 nop_out,
    output logic                 halt_out,
    output logic [EX_W-1:0]      ex_out,
    output logic                 ex_valid_out,
    output logic                 req_valid,
    input  logic                 req_ready,
    output logic                 req_we,
    output logic [ADDR_W-1:0]    req_addr,
    output logic [XLEN-1:0]      req_wdata,
    output logic [XLEN/8-1:0]    req_be,
    input  logic                 rsp_valid,
    input  logic [XLEN-1:0]      rsp_rdata
);

    localparam int unsigned BE_W  = XLEN / 8;
    localparam int unsigned OFF_W = $clog2(BE_W);

    lsu_state_e state_q, state_d;
    logic              we_q, we_d;
    logic [2:0]        funct_q, funct_d;
    logic [OFF_W-1:0]  off_q, off_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic [XLEN-1:0]   lane_q, lane_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [RA_W-1:0]   rd_q, rd_d;
    logic [4:0]        opcode_q, opcode_d;
    logic              nop_q, nop_d;
    logic              halt_q, halt_d;
    logic [EX_W-1:0]   ex_q, ex_d;
    logic              ex_valid_q, ex_valid_d;

    logic            is_load, is_store, is_mem, accept;
    logic [BE_W-1:0] st_be;
    logic [XLEN-1:0] st_lane, ld_result;
    logic            misalign;

    lsu_align #(
        .XLEN (XLEN)
    ) u_align (
        .st_size_i   (funct_in[1:0]),
        .st_off_i    (addr_in[OFF_W-1:0]),
        .st_wdata_i  (wdata_in),
        .st_be_o     (st_be),
        .st_lane_o   (st_lane),
        .misalign_o  (misalign),
        .ld_funct_i  (funct_q),
        .ld_off_i    (off_q),
        .ld_rdata_i  (rsp_rdata),
        .ld_result_o (ld_result)
    );

    assign is_load  = (opcode_in == OP_LOAD);
    assign is_store = (opcode_in == OP_STORE);
    assign is_mem   = is_load || is_store;

    assign out_valid = (state_q == StFin);
    assign in_ready  = (state_q == StIdle) && !(out_valid && stall_in);
    assign accept    = in_valid && in_ready && !flush;

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        funct_d    = funct_q;
        off_d      = off_q;
        addr_d     = addr_q;
        be_d       = be_q;
        lane_d     = lane_q;
        result_d   = result_q;
        rd_d       = rd_q;
        opcode_d   = opcode_q;
        nop_d      = nop_q;
        halt_d     = halt_q;
        ex_d       = ex_q;
        ex_valid_d = ex_valid_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    we_d       = is_store;
                    funct_d    = funct_in;
                    off_d      = addr_in[OFF_W-1:0];
                    addr_d     = {addr_in[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                    be_d       = st_be;
                    lane_d     = st_lane;
                    result_d   = wdata_in;
                    rd_d       = rd_in;
                    opcode_d   = opcode_in;
                    nop_d      = nop_in;
                    halt_d     = halt_in;
                    ex_valid_d = 1'b1;
                    state_d    = StFin;
                    // Upstream exception wins, then illegal size, then misalignment.
                    if (ex_valid_in) begin
                        ex_d = ex_in;
                    end else if (is_mem && !funct_legal(funct_in, is_store, XLEN)) begin
                        ex_d = EX_W'(EX_ILLEGAL);
                    end else if (is_mem && misalign) begin
                        ex_d = is_store ? EX_W'(EX_ST_MISALIGN) : EX_W'(EX_LD_MISALIGN);
                    end else begin
                        ex_d       = '0;
                        ex_valid_d = 1'b0;
                        state_d    = is_mem ? StReq : StFin;
                    end
                end
            end
            StReq: begin
                // An accepted request stands even when flushed; a load must then drain.
                if (req_ready) begin
                    if (flush) state_d = we_q ? StIdle : StDrain;
                    else       state_d = we_q ? StFin : StWait;
                end else if (flush) begin
                    state_d = StIdle;
                end
            end
            StWait: begin
                if (rsp_valid) begin
                    result_d = ld_result;
                    state_d  = flush ? StIdle : StFin;
                end else if (flush) begin
                    state_d = StDrain;
                end
            end
            StFin: begin
                if (flush || !stall_in) state_d = StIdle;
            end
            StDrain: begin
                if (rsp_valid) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            we_q       <= 1'b0;
            funct_q    <= '0;
            off_q      <= '0;
            addr_q     <= '0;
            be_q       <= '0;
            lane_q     <= '0;
            result_q   <= '0;
            rd_q       <= '0;
            opcode_q   <= '0;
            nop_q      <= 1'b0;
            halt_q     <= 1'b0;
            ex_q       <= '0;
            ex_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            funct_q    <= funct_d;
            off_q      <= off_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            lane_q     <= lane_d;
            result_q   <= result_d;
            rd_q       <= rd_d;
            opcode_q   <= opcode_d;
            nop_q      <= nop_d;
            halt_q     <= halt_d;
            ex_q       <= ex_d;
            ex_valid_q <= ex_valid_d;
        end
    end

    assign req_valid    = (state_q == StReq);
    assign req_we       = req_valid && we_q;
    assign req_addr     = addr_q;
    assign req_wdata    = lane_q;
    assign req_be       = req_valid ? be_q : '0;
    assign result_out   = result_q;
    assign rd_out       = rd_q;
    assign opcode_out   = opcode_q;
    assign nop_out      = nop_q;
    assign halt_out     = out_valid && halt_q;
    assign ex_out       = ex_q;
    assign ex_valid_out = out_valid && ex_valid_q;

endmodule

// File: tb/tb_lsu_stage.sv
// Directed bench for lsu_stage: 32-bit instance for most vectors, plus a
// 64-bit instance for doubleword strobes and word sign extension.
module tb_lsu_stage;
    import lsu_stage_pkg::*;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, stall_in, req_ready, rsp_valid;
    logic [4:0]  opcode_in;
    logic [2:0]  funct_in;
    logic [31:0] addr_in, wdata_in, rsp_rdata;
    logic [4:0]  rd_in;
    logic        nop_in, halt_in, ex_valid_in;
    logic [3:0]  ex_in;

    logic        in_ready, out_valid, nop_out, halt_out, ex_valid_out, req_valid, req_we;
    logic [31:0] result_out, req_addr, req_wdata;
    logic [4:0]  rd_out, opcode_out;
    logic [3:0]  ex_out, req_be;

    logic        d64_in_valid, d64_req_ready, d64_rsp_valid;
    logic [63:0] d64_wdata, d64_rsp_rdata;
    logic        d64_in_ready, d64_out_valid, d64_nop_out, d64_halt_out, d64_ex_valid_out;
    logic        d64_req_valid, d64_req_we;
    logic [63:0] d64_result_out, d64_req_wdata;
    logic [31:0] d64_req_addr;
    logic [4:0]  d64_rd_out, d64_opcode_out;
    logic [3:0]  d64_ex_out;
    logic [7:0]  d64_req_be;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    lsu_stage #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .opcode_in(opcode_in), .funct_in(funct_in), .addr_in(addr_in), .wdata_in(wdata_in),
        .rd_in(rd_in), .nop_in(nop_in), .halt_in(halt_in), .ex_in(ex_in),
        .ex_valid_in(ex_valid_in), .out_valid(out_valid), .stall_in(stall_in),
        .result_out(result_out), .rd_out(rd_out), .opcode_out(opcode_out), .nop_out(nop_out),
        .halt_out(halt_out), .ex_out(ex_out), .ex_valid_out(ex_valid_out),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata)
    );

    lsu_stage #(.XLEN(64)) dut64 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(d64_in_valid),
        .in_ready(d64_in_ready), .opcode_in(opcode_in), .funct_in(funct_in),
        .addr_in(addr_in), .wdata_in(d64_wdata), .rd_in(rd_in), .nop_in(nop_in),
        .halt_in(halt_in), .ex_in(ex_in), .ex_valid_in(ex_valid_in),
        .out_valid(d64_out_valid), .stall_in(stall_in), .result_out(d64_result_out),
        .rd_out(d64_rd_out), .opcode_out(d64_opcode_out), .nop_out(d64_nop_out),
        .halt_out(d64_halt_out), .ex_out(d64_ex_out), .ex_valid_out(d64_ex_valid_out),
        .req_valid(d64_req_valid), .req_ready(d64_req_ready), .req_we(d64_req_we),
        .req_addr(d64_req_addr), .req_wdata(d64_req_wdata), .req_be(d64_req_be),
        .rsp_valid(d64_rsp_valid), .rsp_rdata(d64_rsp_rdata)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] op, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] wd, input logic [4:0] rd);
        opcode_in = op;
        funct_in  = f;
        addr_in   = a;
        wdata_in  = wd;
        rd_in     = rd;
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
    endtask

    // Load with `lat` cycles of req_ready low, then a one-cycle response.
    task automatic load_txn(input string tag, input logic [2:0] f, input logic [31:0] a,
                            input logic [31:0] rdat, input int lat);
        issue(OP_LOAD, f, a, 32'h0, 5'd3);
        for (int i = 0; i <= lat; i++) begin
            check({tag, "_req_valid"}, req_valid, 1);
            check({tag, "_req_addr"}, req_addr, {a[31:2], 2'b00});
            req_ready = (i == lat);
            tick();
        end
        req_ready = 1'b0;
        check({tag, "_wait_noreq"}, req_valid, 0);
        rsp_valid = 1'b1;
        rsp_rdata = rdat;
        tick();
        rsp_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; stall_in = 1'b0;
        req_ready = 1'b0; rsp_valid = 1'b0; rsp_rdata = '0;
        opcode_in = '0; funct_in = '0; addr_in = '0; wdata_in = '0; rd_in = '0;
        nop_in = 1'b0; halt_in = 1'b0; ex_in = '0; ex_valid_in = 1'b0;
        d64_in_valid = 1'b0; d64_req_ready = 1'b0; d64_rsp_valid = 1'b0;
        d64_wdata = '0; d64_rsp_rdata = '0;
        tick();
        tick();
        reset = 1'b0;

        check("rst_out_valid", out_valid, 0);
        check("rst_req_valid", req_valid, 0);
        check("rst_req_we", req_we, 0);
        check("rst_req_be", req_be, 0);
        check("rst_result", result_out, 0);
        check("rst_ex_valid", ex_valid_out, 0);
        check("rst_halt", halt_out, 0);
        check("rst_in_ready", in_ready, 1);

        // Non-memory op with halt flag passed through
        halt_in = 1'b1;
        issue(5'b01100, 3'b000, 32'h0, 32'h1234, 5'd7);
        halt_in = 1'b0;
        check("alu_valid", out_valid, 1);
        check("alu_result", result_out, 32'h1234);
        check("alu_rd", rd_out, 7);
        check("alu_halt", halt_out, 1);
        check("alu_noreq", req_valid, 0);
        check("alu_in_ready", in_ready, 0);
        tick();
        check("alu_done", out_valid, 0);

        load_txn("lb", F_B, 32'h103, 32'h80FF_FFFF, 2);
        check("lb_valid", out_valid, 1);
        check("lb_result", result_out, 32'hFFFF_FF80);
        check("lb_ex_valid", ex_valid_out, 0);
        tick();

        load_txn("lbu", F_BU, 32'h103, 32'h80FF_FFFF, 0);
        check("lbu_result", result_out, 32'h0000_0080);
        tick();

        issue(OP_STORE, F_H, 32'h202, 32'h0000_ABCD, 5'd0);
        check("sh_req_valid", req_valid, 1);
        check("sh_req_we", req_we, 1);
        check("sh_req_be", req_be, 4'b1100);
        check("sh_req_addr", req_addr, 32'h200);
        check("sh_lane", req_wdata[31:16], 16'hABCD);
        check("sh_no_out", out_valid, 0);
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        check("sh_valid", out_valid, 1);
        check("sh_result", result_out, 32'h0000_ABCD);
        check("sh_req_done", req_valid, 0);
        tick();

        issue(OP_LOAD, F_W, 32'h301, 32'h0, 5'd1);
        check("lw_mis_noreq", req_valid, 0);
        check("lw_mis_valid", out_valid, 1);
        check("lw_mis_exv", ex_valid_out, 1);
        check("lw_mis_ex", ex_out, EX_LD_MISALIGN);
        tick();

        ex_valid_in = 1'b1;
        ex_in = 4'd2;
        issue(OP_LOAD, F_W, 32'h301, 32'h0, 5'd1);
        ex_valid_in = 1'b0;
        ex_in = 4'd0;
        check("up_ex_noreq", req_valid, 0);
        check("up_ex_exv", ex_valid_out, 1);
        check("up_ex_code", ex_out, 2);
        tick();

        issue(OP_STORE, F_W, 32'h402, 32'h1, 5'd0);
        check("sw_mis_noreq", req_valid, 0);
        check("sw_mis_ex", ex_out, EX_ST_MISALIGN);
        tick();

        issue(OP_LOAD, F_D, 32'h0, 32'h0, 5'd1);
        check("ld32_illegal_noreq", req_valid, 0);
        check("ld32_illegal_ex", ex_out, EX_ILLEGAL);
        check("ld32_illegal_exv", ex_valid_out, 1);
        tick();

        // Flush while waiting for the response: the late response must be dropped
        issue(OP_LOAD, F_W, 32'h300, 32'h0, 5'd4);
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fl_wait_out0", out_valid, 0);
        check("fl_wait_busy", in_ready, 0);
        tick();
        check("fl_wait_out1", out_valid, 0);
        rsp_valid = 1'b1;
        rsp_rdata = 32'h0000_DEAD;
        tick();
        rsp_valid = 1'b0;
        check("fl_drained_out", out_valid, 0);
        check("fl_drained_ready", in_ready, 1);
        issue(5'b01100, 3'b000, 32'h0, 32'h55, 5'd9);
        check("fl_next_valid", out_valid, 1);
        check("fl_next_result", result_out, 32'h55);
        tick();

        issue(OP_LOAD, F_W, 32'h500, 32'h0, 5'd4);
        check("fl_req_valid", req_valid, 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fl_req_dropped", req_valid, 0);
        check("fl_req_ready", in_ready, 1);
        check("fl_req_out", out_valid, 0);

        stall_in = 1'b1;
        load_txn("lh_stall", F_H, 32'h302, 32'h8001_0000, 1);
        for (int i = 0; i < 3; i++) begin
            check("stall_valid", out_valid, 1);
            check("stall_result", result_out, 32'hFFFF_8001);
            check("stall_in_ready", in_ready, 0);
            if (i < 2) tick();
        end
        stall_in = 1'b0;
        tick();
        check("stall_release", out_valid, 0);
        check("stall_ready", in_ready, 1);

        // 64-bit instance: doubleword load and sign-extended word from upper half
        opcode_in = OP_LOAD;
        funct_in  = F_D;
        addr_in   = 32'h8;
        d64_in_valid = 1'b1;
        tick();
        d64_in_valid = 1'b0;
        check("ld64_req_valid", d64_req_valid, 1);
        check("ld64_req_be", d64_req_be, 8'hFF);
        check("ld64_req_addr", d64_req_addr, 32'h8);
        d64_req_ready = 1'b1;
        tick();
        d64_req_ready = 1'b0;
        d64_rsp_valid = 1'b1;
        d64_rsp_rdata = 64'h1122_3344_5566_7788;
        tick();
        d64_rsp_valid = 1'b0;
        check("ld64_result", d64_result_out, 64'h1122_3344_5566_7788);
        tick();

        funct_in = F_W;
        addr_in  = 32'hC;
        d64_in_valid = 1'b1;
        tick();
        d64_in_valid = 1'b0;
        check("lw64_req_be", d64_req_be, 8'hF0);
        check("lw64_req_addr", d64_req_addr, 32'h8);
        d64_req_ready = 1'b1;
        tick();
        d64_req_ready = 1'b0;
        d64_rsp_valid = 1'b1;
        d64_rsp_rdata = 64'h8000_0001_1234_5678;
        tick();
        d64_rsp_valid = 1'b0;
        check("lw64_result", d64_result_out, 64'hFFFF_FFFF_8000_0001);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
